// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: control, layer and result signals between network control, sequencer and layer.
interface layer_sequencer_if #(
  parameter int NEURON_COUNT = 2,
  parameter int COUNT_WIDTH  = 9
);
  logic                            start;
  logic                            abort;
  logic [NEURON_COUNT-1:0]         layer_output;
  logic                            layer_n_rst;
  logic                            busy;
  logic                            done;
  logic                            result_valid;
  logic [NEURON_COUNT*COUNT_WIDTH-1:0] counts;
  modport master (
    output start, abort, layer_output,
    input  layer_n_rst, busy, done, result_valid, counts
  );
  modport slave (
    input  start, abort, layer_output,
    output layer_n_rst, busy, done, result_valid, counts
  );
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs one clear/warm-up/accumulate window of a bitstream layer and publishes per-neuron ones-counts.
module layer_sequencer #(
  parameter int NEURON_COUNT  = 2,
  parameter int STREAM_LENGTH = 256,
  parameter int WARMUP_CYCLES = 4,
  parameter int COUNT_WIDTH   = $clog2(STREAM_LENGTH + 1)
) (
  input logic clk,
  input logic n_rst,
  layer_sequencer_if.slave bus
);
  localparam int MAX_CYC = (WARMUP_CYCLES > STREAM_LENGTH) ? WARMUP_CYCLES : STREAM_LENGTH;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, WARMUP, ACCUM, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [COUNT_WIDTH-1:0] acc [NEURON_COUNT];
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    unique case (state)
      IDLE:   nxt = bus.start ? CLEAR : IDLE;
      CLEAR: begin
        nxt     = (WARMUP_CYCLES == 0) ? ACCUM : WARMUP;
        cnt_nxt = '0;
      end
      WARMUP: begin
        nxt     = (cnt == CW'(WARMUP_CYCLES - 1)) ? ACCUM : WARMUP;
        cnt_nxt = (cnt == CW'(WARMUP_CYCLES - 1)) ? '0 : cnt + 1'b1;
      end
      ACCUM: begin
        nxt     = (cnt == CW'(STREAM_LENGTH - 1)) ? DONE : ACCUM;
        cnt_nxt = (cnt == CW'(STREAM_LENGTH - 1)) ? '0 : cnt + 1'b1;
      end
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // abort overrides even the final accumulate sample
    if (bus.abort && (state == CLEAR || state == WARMUP || state == ACCUM)) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= IDLE;
      cnt              <= '0;
      bus.layer_n_rst  <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.counts       <= '0;
      for (int i = 0; i < NEURON_COUNT; i++) acc[i] <= '0;
    end else begin
      state           <= nxt;
      cnt             <= cnt_nxt;
      bus.layer_n_rst <= (nxt == WARMUP) || (nxt == ACCUM);
      if (state == IDLE && bus.start) bus.result_valid <= 1'b0;
      else if (nxt == DONE) bus.result_valid <= 1'b1;
      for (int i = 0; i < NEURON_COUNT; i++) begin
        if (state == CLEAR) acc[i] <= '0;
        else if (state == ACCUM) acc[i] <= acc[i] + COUNT_WIDTH'(bus.layer_output[i]);
        // publish including the sample taken on this same edge
        if (nxt == DONE) bus.counts[i*COUNT_WIDTH +: COUNT_WIDTH] <= acc[i] + COUNT_WIDTH'(bus.layer_output[i]);
      end
    end
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: randomized windows scored against a per-window ones-count model.
module tb_layer_sequencer;
  localparam int N  = 2;
  localparam int S  = 256;
  localparam int W  = 4;
  localparam int CW = $clog2(S + 1);
  localparam int P  = 3 + W + S;
  typedef struct {
    logic [N*CW-1:0] counts;
    int              done_cyc;
  } exp_t;
  logic clk = 0;
  logic n_rst = 0;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [N*CW-1:0] last_counts = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  layer_sequencer_if #(.NEURON_COUNT(N), .COUNT_WIDTH(CW)) bus();
  layer_sequencer #(.NEURON_COUNT(N), .STREAM_LENGTH(S), .WARMUP_CYCLES(W)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (n_rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 expected 0", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("counts", 64'(bus.counts), 64'(mon_e.counts));
        check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
        check("result_valid_at_done", 64'(bus.result_valid), 64'd1);
      end
    end
  end
  function automatic logic [N-1:0] pat(input int mode, input int o);
    int a = o - (2 + W);
    bit in_win = (o >= 2 + W) && (o <= 1 + W + S);
    case (mode)
      1: return '1;
      2: return in_win ? {1'b0, a % 2 == 0} : N'($urandom);
      3: return (o <= 1 + W) ? '1 : '0;
      default: return N'($urandom);
    endcase
  endfunction
  // abort_k > 0 raises abort on the k-th accumulate cycle
  task automatic run_window(input int mode, input int abort_k, input bit repulse);
    logic [N-1:0] seq [0:W+S+2];
    logic [N*CW-1:0] exp_c = '0;
    int sums [N];
    int e;
    exp_t x;
    for (int i = 0; i < N; i++) sums[i] = 0;
    for (int o = 0; o <= W + S + 2; o++) begin
      seq[o] = pat(mode, o);
      if (o >= 2 + W && o <= 1 + W + S)
        for (int i = 0; i < N; i++) sums[i] += int'(seq[o][i]);
    end
    for (int i = 0; i < N; i++) exp_c[i*CW +: CW] = CW'(sums[i]);
    @(negedge clk);
    e = cyc + 1;
    if (abort_k == 0) begin
      x.counts = exp_c;
      x.done_cyc = e + 1 + W + S;
      sb.push_back(x);
    end
    for (int r = -1; r <= W + S + 2; r++) begin
      if (r >= 0) @(negedge clk);
      bus.start = (r == -1) || (repulse && (r == W + 10 || r == W + S + 1));
      bus.abort = (abort_k > 0) && (r == W + abort_k);
      bus.layer_output = seq[r + 1];
      if (abort_k > 0 && r == W + 1 + abort_k) begin
        bus.start = 0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_layer_n_rst", 64'(bus.layer_n_rst), 64'd0);
        check("abort_result_valid", 64'(bus.result_valid), 64'd0);
        check("abort_counts", 64'(bus.counts), 64'(last_counts));
        break;
      end
      check("busy", 64'(bus.busy), 64'(r >= 0 && r <= W + S + 1));
      check("layer_n_rst", 64'(bus.layer_n_rst), 64'(r >= 1 && r <= W + S));
      if (r >= 0) check("result_valid", 64'(bus.result_valid), 64'(r >= W + S + 1));
    end
    bus.start = 0;
    bus.abort = 0;
    if (abort_k == 0) last_counts = exp_c;
  endtask
  task automatic held_start();
    exp_t x;
    int e;
    @(negedge clk);
    e = cyc + 1;
    bus.start = 1;
    bus.layer_output = '1;
    x.counts = {N{CW'(S)}};
    x.done_cyc = e + 1 + W + S;
    sb.push_back(x);
    x.done_cyc = e + P + 1 + W + S;
    sb.push_back(x);
    for (int i = 0; i < P + 1; i++) @(negedge clk);
    bus.start = 0;
    for (int i = 0; i < 2 * P && sb.size() != 0; i++) @(negedge clk);
    check("held_start_drained", 64'(sb.size()), 64'd0);
    @(negedge clk);
    check("held_start_idle", 64'(bus.busy), 64'd0);
    last_counts = x.counts;
  endtask
  initial begin
    bus.start = 0;
    bus.abort = 0;
    bus.layer_output = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result_valid", 64'(bus.result_valid), 64'd0);
    check("rst_counts", 64'(bus.counts), 64'd0);
    check("rst_layer_n_rst", 64'(bus.layer_n_rst), 64'd0);
    n_rst = 1;
    run_window(1, 0, 0);
    run_window(2, 0, 0);
    run_window(3, 0, 0);
    run_window(1, 0, 0);
    run_window(0, 100, 0);
    run_window(0, 0, 1);
    run_window(0, 0, 0);
    run_window(1, S, 0);
    run_window(0, 0, 0);
    held_start();
    @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (W + 50) @(negedge clk);
    #2 n_rst = 0;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_done", 64'(bus.done), 64'd0);
    check("async_rst_result_valid", 64'(bus.result_valid), 64'd0);
    check("async_rst_counts", 64'(bus.counts), 64'd0);
    check("async_rst_layer_n_rst", 64'(bus.layer_n_rst), 64'd0);
    last_counts = '0;
    @(negedge clk);
    n_rst = 1;
    run_window(0, 0, 0);
    run_window(2, 0, 1);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
